// File: rtl/clock_pkg.sv
// Shared types and constants for the time-setting controller and its BCD field stepper.
// Time word layout is {HH, MM, SS}, two BCD digits per field.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  localparam int HH_LSB = 16;
  localparam int MM_LSB = 8;
  localparam int SS_LSB = 0;

  // Replaces the field selected by st; RUN leaves the word untouched.
  function automatic logic [23:0] put_field(input logic [23:0] t, input state_e st,
                                            input logic [7:0] v);
    logic [23:0] r;
    r = t;
    unique case (st)
      SET_HOUR: r[HH_LSB +: 8] = v;
      SET_MIN:  r[MM_LSB +: 8] = v;
      SET_SEC:  r[SS_LSB +: 8] = v;
      default:  r = t;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] field_mask(input state_e st);
    logic [5:0] m;
    unique case (st)
      SET_HOUR: m = 6'b110000;
      SET_MIN:  m = 6'b001100;
      SET_SEC:  m = 6'b000011;
      default:  m = 6'b000000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// Single-step a two-digit BCD field up or down with wrap at 00/max.
// An out-of-range or non-BCD value snaps to 00 (up) or max (down).
module bcd_field_step (
  input  logic [7:0] value,
  input  logic [7:0] max,
  input  logic       up,
  input  logic       dn,
  output logic [7:0] next
);

  logic legal;

  always_comb begin
    legal = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
    next  = value;
    if (up && !dn) begin
      if (!legal || value == max)  next = 8'h00;
      else if (value[3:0] == 4'd9) next = {value[7:4] + 4'd1, 4'd0};
      else                         next = {value[7:4], value[3:0] + 4'd1};
    end else if (dn && !up) begin
      if (!legal || value == 8'h00) next = max;
      else if (value[3:0] == 4'd0)  next = {value[7:4] - 4'd1, 4'd9};
      else                          next = {value[7:4], value[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set mode controller for the HH:MM:SS counter chain: edits a shadow copy of the
// time field by field and writes it back with a one-cycle parallel load.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_TICKS   = 5,
  parameter int TIMEOUT_TICKS = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] cur_time,
  output logic        cnt_en,
  output logic        load,
  output logic [23:0] load_time,
  output logic [5:0]  les,
  output logic [1:0]  mode
);

  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_e          state_q, state_d;
  logic [23:0]     shadow_q, shadow_d;
  logic            load_q, load_d;
  logic [23:0]     load_time_q, load_time_d;
  logic            phase_q, phase_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic [TW-1:0]   to_q, to_d;
  logic [2:0]      btn_prev_q, btn_prev_d;  // {mode, inc, dec}
  logic [2:0]      press_q, press_d;

  logic            in_set, step_up, step_dn, any_press;
  logic [7:0]      fld_val, fld_max, fld_next;

  assign in_set    = (state_q != RUN);
  assign any_press = |press_q;
  assign step_up   = in_set & ~press_q[2] &  press_q[1] & ~press_q[0];
  assign step_dn   = in_set & ~press_q[2] & ~press_q[1] &  press_q[0];

  always_comb begin
    fld_val = 8'h00;
    fld_max = MINSEC_MAX;
    unique case (state_q)
      SET_HOUR: begin
        fld_val = shadow_q[HH_LSB +: 8];
        fld_max = HOUR_MAX;
      end
      SET_MIN:  fld_val = shadow_q[MM_LSB +: 8];
      SET_SEC:  fld_val = shadow_q[SS_LSB +: 8];
      default:  fld_val = 8'h00;
    endcase
  end

  bcd_field_step u_step (
    .value (fld_val),
    .max   (fld_max),
    .up    (step_up),
    .dn    (step_dn),
    .next  (fld_next)
  );

  always_comb begin
    btn_prev_d  = {btn_mode, btn_inc, btn_dec};
    press_d     = {btn_mode, btn_inc, btn_dec} & ~btn_prev_q;
    state_d     = state_q;
    shadow_d    = shadow_q;
    load_d      = 1'b0;
    load_time_d = load_time_q;
    phase_d     = phase_q;
    blink_d     = blink_q;
    to_d        = to_q;

    if (!in_set) begin
      if (press_q[2]) begin
        state_d  = SET_HOUR;
        shadow_d = cur_time;
      end
    end else if (press_q[2]) begin
      if (state_q == SET_SEC) begin
        state_d     = RUN;
        load_d      = 1'b1;
        load_time_d = shadow_q;
      end else begin
        state_d = state_e'(state_q + 2'd1);
      end
    end else begin
      shadow_d = put_field(shadow_q, state_q, fld_next);
      if (any_press) begin
        to_d = '0;
      end else if (tick_in) begin
        if (to_q == TW'(TIMEOUT_TICKS - 1)) state_d = RUN;
        else                                to_d    = to_q + TW'(1);
      end
      if (tick_in) begin
        if (blink_q == BW'(BLINK_TICKS - 1)) begin
          blink_d = '0;
          phase_d = ~phase_q;
        end else begin
          blink_d = blink_q + BW'(1);
        end
      end
    end

    // Every state transition restarts both the idle timer and the blink cadence.
    if (state_d != state_q) begin
      to_d    = '0;
      blink_d = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      shadow_q    <= '0;
      load_q      <= 1'b0;
      load_time_q <= '0;
      phase_q     <= 1'b0;
      blink_q     <= '0;
      to_q        <= '0;
      btn_prev_q  <= '0;
      press_q     <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      load_q      <= load_d;
      load_time_q <= load_time_d;
      phase_q     <= phase_d;
      blink_q     <= blink_d;
      to_q        <= to_d;
      btn_prev_q  <= btn_prev_d;
      press_q     <= press_d;
    end
  end

  assign cnt_en    = tick_in & (state_q == RUN) & ~load_q & ~rst;
  assign load      = load_q;
  assign load_time = load_time_q;
  assign les       = phase_q ? field_mask(state_q) : 6'b000000;
  assign mode      = state_q;

endmodule
